// File: rtl/disp_pkg.sv
// Shared types, constants and helpers for the seven-segment scan controller.
package disp_pkg;

  typedef logic [6:0] seg7_t;

  localparam int          N_DIGITS  = 8;
  localparam logic [3:0]  CTRL_OFF  = 4'd8;
  localparam seg7_t       SEG_BLANK = 7'h00;
  localparam seg7_t       SEG_ZERO  = 7'h3F;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam seg7_t HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Lowest enabled digit strictly above cur (wrapping); cur itself is only
  // reached on the final rotation step, i.e. when it is the sole enabled digit.
  function automatic logic [3:0] next_digit(input logic [3:0] cur,
                                            input logic [7:0] en);
    logic [2:0] base;
    logic [2:0] idx;
    logic       found;
    next_digit = CTRL_OFF;
    found      = 1'b0;
    base       = (cur == CTRL_OFF) ? 3'd0 : cur[2:0] + 3'd1;
    for (int k = 0; k < N_DIGITS; k++) begin
      idx = base + 3'(k);
      if (!found && en[idx]) begin
        next_digit = {1'b0, idx};
        found      = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder.
module hex_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg7_t      seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit seven-segment scan controller with tear-free frame commits.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value_in,
  input  logic        load,
  input  logic [7:0]  digit_en,
  output seg7_t       dis0,
  output seg7_t       dis1,
  output seg7_t       dis2,
  output seg7_t       dis3,
  output seg7_t       dis4,
  output seg7_t       dis5,
  output seg7_t       dis6,
  output seg7_t       dis7,
  output logic [3:0]  Control,
  output logic        tick,
  output logic        frame_done
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("display_scan_ctrl: CLK_HZ/REFRESH_HZ must be at least 2");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic [3:0]    next_idx;
  logic          frame_bnd;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   disp_val_q, disp_val_d;
  logic          pending_q, pending_d;
  logic          commit;
  logic [31:0]   commit_val;
  seg7_t         seg_raw [N_DIGITS];
  seg7_t         dis_q   [N_DIGITS];
  seg7_t         dis_d   [N_DIGITS];

  assign tick       = (presc_q == PRESC_MAX);
  assign next_idx   = next_digit(ctrl_q, digit_en);
  assign frame_bnd  = tick && ((ctrl_q == CTRL_OFF) || (next_idx <= ctrl_q));
  assign frame_done = frame_bnd;
  assign Control    = ctrl_q;

  // A load landing on a boundary bypasses the shadow so it is not delayed a frame.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    presc_d    = tick ? '0 : presc_q + PW'(1);
    ctrl_d     = tick ? next_idx : ctrl_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    commit     = 1'b0;
    commit_val = shadow_q;
    if (load) begin
      shadow_d = value_in;
      if (frame_bnd) begin
        commit     = 1'b1;
        commit_val = value_in;
        pending_d  = 1'b0;
      end else begin
        pending_d  = 1'b1;
      end
    end else if (frame_bnd && pending_q) begin
      commit    = 1'b1;
      pending_d = 1'b0;
    end
    disp_val_d = commit ? commit_val : disp_val_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      ctrl_q     <= CTRL_OFF;
      shadow_q   <= '0;
      disp_val_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // sample pre-edge values regardless of statement order.
      presc_q    <= presc_d;
      ctrl_q     <= ctrl_d;
      shadow_q   <= shadow_d;
      disp_val_q <= disp_val_d;
      pending_q  <= pending_d;
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    hex_to_seg7 u_dec (
      .nibble_i (disp_val_q[4*g +: 4]),
      .seg_o    (seg_raw[g])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] blank_q, blank_d;

  // Digit i (i >= 1) blanks when it and all higher nibbles are zero.
  function automatic logic [N_DIGITS-1:0] lead_zero_mask(input logic [31:0] v);
    logic run;
    run            = 1'b1;
    lead_zero_mask = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      run               = run & (v[4*i +: 4] == 4'h0);
      lead_zero_mask[i] = run;
    end
  endfunction

  assign blank_d = commit ? lead_zero_mask(commit_val) : blank_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) blank_q <= '0;
    else        blank_q <= blank_d;
  end

  always_comb begin
    for (int i = 0; i < N_DIGITS; i++)
      dis_d[i] = blank_q[i] ? SEG_BLANK : seg_raw[i];
  end
`else
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++)
      dis_d[i] = seg_raw[i];
  end
`endif

  // NOTE: the segment registers are a small flop array, not RAM, so they take
  // a reset value and show "0" straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_DIGITS; i++) dis_q[i] <= SEG_ZERO;
    end else begin
      for (int i = 0; i < N_DIGITS; i++) dis_q[i] <= dis_d[i];
    end
  end

  assign dis0 = dis_q[0];
  assign dis1 = dis_q[1];
  assign dis2 = dis_q[2];
  assign dis3 = dis_q[3];
  assign dis4 = dis_q[4];
  assign dis5 = dis_q[5];
  assign dis6 = dis_q[6];
  assign dis7 = dis_q[7];

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Upstream driver for the 8-digit seven-segment output multiplexer.
- Captures a 32-bit hex value (8 nibbles) and decodes each nibble into an active-high 7-segment pattern, dis0..dis7.
- Generates the time-multiplexed digit-select index Control that the mux consumes.
- New values are committed only at frame boundaries, so a displayed frame never mixes old and new digits (no tearing).

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- REFRESH_HZ, 1000, per-digit dwell rate. DIV = CLK_HZ/REFRESH_HZ, elaboration error if DIV < 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low: asserted at 0, released synchronously to clk.
- value_in  in  32  hex value; nibble i goes to digit i.
- load  in  1  one-cycle strobe; captures value_in into the shadow register.
- digit_en  in  8  per-digit enable; a disabled digit is skipped in the scan.
- dis0..dis7  out  7 each  active-high segments {g,f,e,d,c,b,a}.
- Control  out  4  digit index 0..7; 8 means all digits off (the mux default branch).
- tick  out  1  one-cycle pulse on every digit advance.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset values:
  - prescaler = 0, shadow = 0, disp_val = 0, pending = 0.
  - Control = 4'd8, tick = 0, frame_done = 0.
  - dis0..dis7 = 7'h3F (decoded "0").
- Prescaler:
  - Counts 0..DIV-1, then wraps to 0.
  - tick = 1 during the cycle in which the prescaler equals DIV-1.
- Scan, evaluated on a tick cycle; Control updates at the next clock edge:
  - Next index = lowest enabled digit strictly above Control, wrapping 7 -> 0. The search includes Control itself only when it is the sole enabled digit.
  - From Control = 8, next index = lowest enabled digit.
  - If digit_en = 0, Control goes to 8 and stays there while digit_en = 0.
  - A digit disabled mid-dwell keeps its slot until the next tick. No early switch.
- Frame boundary:
  - A tick cycle whose next index is <= the current Control, or whose current Control = 8.
  - frame_done pulses that same cycle.
- Load and commit:
  - load: shadow <= value_in and pending <= 1. If several loads arrive before a commit, the last one wins.
  - On a frame boundary with pending = 1: disp_val <= shadow and pending <= 0.
  - load coinciding with a boundary: disp_val <= value_in directly and pending <= 0.
- Decode:
  - dis_i is registered from disp_val[4i+3:4i], so it updates 1 clk after disp_val.
  - Table: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- End-to-end latency: a load on a boundary cycle shows on dis* 2 clk later. Otherwise it shows 2 clk after the next boundary.
- Reset mid-operation: all state returns to reset values immediately, and the pending load is discarded.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: at commit, digit i (i >= 1) is blanked to 7'h00 when it and every higher nibble are 0. Digit 0 is never blanked, so value 0 shows a single "0". A per-digit blank mask is registered alongside disp_val.
- Undefined: all eight nibbles are always decoded. No blank-mask logic is generated.

Decomposition:
- Package disp_pkg holds:
  - typedef seg7_t (logic [6:0]).
  - SEG_BLANK = 7'h00.
  - CTRL_OFF = 4'd8.
  - N_DIGITS = 8.
  - The 16-entry hex-to-segment constant table.
- Sub-module hex_to_seg7: combinational nibble -> seg7_t decoder, instantiated 8 times and registered by the parent.

Test Plan (CLK_HZ=8, REFRESH_HZ=2 -> DIV=4):
- Reset release, digit_en=8'hFF -> Control goes 8,0,1,...,7,0 with a new value every 4 clk; frame_done pulses on the 8->0 and 7->0 steps; dis* all 7'h3F.
- load with value_in=32'h89AB_CDEF in mid-frame -> dis* unchanged until the boundary; 2 clk after it, dis0=71 dis1=79 dis2=5E dis3=39 dis4=7C dis5=77 dis6=6F dis7=7F.
- Two loads (32'h1111_1111 then 32'h2222_2222) in one frame -> only 5B appears on all digits; 06 never appears.
- digit_en=8'b0000_0101 -> Control sequence 0,2,0,2...; then digit_en=0 -> Control=8 at the next tick and held there.
- load coincident with a tick whose next index is 0 -> disp_val updates that edge and pending stays 0; reset pulse mid-frame -> Control=8 and dis*=3F.
- With LEADING_ZERO_BLANK_EN defined, load 32'h0000_0A05 -> dis7..dis3 = 00, dis2=77, dis1=3F, dis0=6D.
